uart_rx_fifo1: RTL



---
 rtl/uart_rx_fifo1.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo1.sv
// uart_rx_fifo1: 8N1 UART receiver with a one-entry valid/ready holding register.
// The rx line is synchronized through two flops. A down-counter is reloaded at
// each bit so that the line is sampled at the midpoint of every bit.
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   rx         asynchronous serial line, idles high
//   data       received byte, meaningful while valid=1
//   valid      holding register contains an unconsumed byte
//   ready      consumer takes data when valid && ready at a rising edge
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, holding register full
module uart_rx_fifo1 #(
  parameter int CLK_DIV = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_sync1, r_sync2;
  logic          w_rx_s;
  logic          w_tick;

  // Synchronizer resets to the idle level so the line looks idle right after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= WAIT_HIGH;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a delivery later in this block overrides it.
      if (valid && ready) valid <= 1'b0;

      // Free-running decrement while framing; reloads below take priority.
      if (r_state != IDLE && r_state != WAIT_HIGH) r_cnt <= r_cnt - CW'(1);

      case (r_state)
        WAIT_HIGH: if (w_rx_s) r_state <= IDLE;
        IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= HALF;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_state <= IDLE;            // glitch, not a real start bit
            end else begin
              r_cnt     <= FULL;
              r_bit_cnt <= '0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {w_rx_s, r_shift[7:1]}; // LSB arrives first
            r_cnt   <= FULL;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (w_rx_s) begin
              // Re-arm at mid stop bit so back-to-back frames are not missed.
              r_state <= IDLE;
              if (!valid || ready) begin
                data  <= r_shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= WAIT_HIGH;
            end
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

endmodule
